// File: rtl/ab_burst_sched.sv
// -----------------------------------------------------------------------------
// ab_burst_sched
//   Time-shares one two-input serial detector (a/b in, y out, active-high reset)
//   among NREQ requesters. Requesters stream bursts of (a,b) symbols using a
//   valid/last handshake. The block grants requesters round-robin and holds the
//   detector in reset between bursts. It steers the granted stream into the
//   detector and returns the detector's y result to the winner.
//
//   Ports
//     Clk          rising-edge clock
//     Rst          asynchronous active-low reset
//     req_i        per-requester burst request (level)
//     sym_valid_i  per-requester symbol valid
//     sym_a_i      per-requester symbol bit a
//     sym_b_i      per-requester symbol bit b
//     sym_last_i   per-requester last-symbol flag
//     sym_ready_o  one-hot ready to the granted requester (ARM/STREAM only)
//     gnt_o        one-hot registered grant
//     det_a_o      detector input a
//     det_b_o      detector input b
//     det_rst_o    detector reset, active high
//     det_y_i      detector output y (Moore, reflects symbol of previous edge)
//     done_o       one-cycle pulse to the granted requester at burst close
//     res_y_o      y after the last symbol (valid with done_o)
//     res_any_o    y seen high anywhere in the burst (valid with done_o)
//     err_o        burst closed by a bubble or length overflow (valid with done_o)
//     busy_o       scheduler not idle
// -----------------------------------------------------------------------------
module ab_burst_sched #(
  parameter int NREQ    = 4,
  parameter int CLR_CYC = 1,
  parameter int MAXLEN  = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] sym_valid_i,
  input  logic [NREQ-1:0] sym_a_i,
  input  logic [NREQ-1:0] sym_b_i,
  input  logic [NREQ-1:0] sym_last_i,
  output logic [NREQ-1:0] sym_ready_o,
  output logic [NREQ-1:0] gnt_o,
  output logic            det_a_o,
  output logic            det_b_o,
  output logic            det_rst_o,
  input  logic            det_y_i,
  output logic [NREQ-1:0] done_o,
  output logic            res_y_o,
  output logic            res_any_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(MAXLEN + 1);
  localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ARM, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] g;          // index of the granted requester
  logic [IDW-1:0] rr_ptr;     // highest-priority requester for the next grant
  logic [CW-1:0]  cnt;        // symbols accepted in the current burst
  logic [CCW-1:0] clr_cnt;
  logic           acc_any;    // running OR of sampled y
  logic           acc_err;    // overflow seen, reported at DONE

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan_idx;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (!pick_valid && req_i[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  logic sel_req, sel_valid, sel_last, in_xfer, accept;

  assign sel_req   = req_i[g];
  assign sel_valid = sym_valid_i[g];
  assign sel_last  = sym_last_i[g];
  assign in_xfer   = (state == S_ARM) || (state == S_STREAM);
  assign accept    = in_xfer && sel_valid;

  assign sym_ready_o = in_xfer ? gnt_o : '0;
  assign det_a_o     = accept & sym_a_i[g];
  assign det_b_o     = accept & sym_b_i[g];
  assign done_o      = (state == S_DONE) ? gnt_o : '0;
  assign busy_o      = (state != S_IDLE);

  // The detector runs only while a burst is moving; in ARM it leaves reset
  // exactly on the edge that takes the first symbol.
  always_comb begin
    det_rst_o = 1'b1;
    case (state)
      S_ARM:             det_rst_o = !sel_valid;
      S_STREAM, S_DRAIN: det_rst_o = 1'b0;
      default:           det_rst_o = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= S_IDLE;
      gnt_o     <= '0;
      g         <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      clr_cnt   <= '0;
      acc_any   <= 1'b0;
      acc_err   <= 1'b0;
      res_y_o   <= 1'b0;
      res_any_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            g       <= pick_idx;
            gnt_o   <= NREQ'(1) << pick_idx;
            clr_cnt <= '0;
            state   <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (!sel_req) begin
            gnt_o <= '0;
            state <= S_IDLE;
          end else if (clr_cnt == CCW'(CLR_CYC - 1)) begin
            state <= S_ARM;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        S_ARM: begin
          if (sel_valid) begin
            cnt     <= CW'(1);
            acc_any <= 1'b0;
            acc_err <= 1'b0;
            if (sel_last) begin
              state <= S_DRAIN;
            end else if (MAXLEN == 1) begin
              acc_err <= 1'b1;
              state   <= S_DRAIN;
            end else begin
              state <= S_STREAM;
            end
          end else if (!sel_req) begin
            gnt_o <= '0;
            state <= S_IDLE;
          end
        end

        // req_i is ignored here: once streaming, the burst is framed by last.
        S_STREAM: begin
          acc_any <= acc_any | det_y_i;
          if (sel_valid) begin
            if (sel_last) begin
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
              if (cnt == CW'(MAXLEN - 1)) begin
                acc_err <= 1'b1;
                state   <= S_DRAIN;
              end
            end
          end else begin
            // Bubble: the stream broke, so there is no meaningful final y.
            res_y_o   <= 1'b0;
            res_any_o <= acc_any | det_y_i;
            err_o     <= 1'b1;
            state     <= S_DONE;
          end
        end

        // y now reflects the final symbol taken on the previous edge.
        S_DRAIN: begin
          res_y_o   <= det_y_i;
          res_any_o <= acc_any | det_y_i;
          err_o     <= acc_err;
          state     <= S_DONE;
        end

        S_DONE: begin
          rr_ptr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
          gnt_o  <= '0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
